bus_reg_file: RTL and testbench
===============================

# bus_reg_file

Register bank on the receiving side of the common bus: holds AR, PC, DR, AC, IR and TR plus the 4-bit sequence counter SC. Each register loads, increments or clears under per-register control strobes from the hardwired control unit. Register outputs feed back to the bus multiplexer as its sources. The block also presents the memory write port: address from AR, data from the bus.

## Interface

Parameters:
- Bits, 16, width of the bus and of DR, AC, IR, TR; AR and PC are fixed at 12 bits

Ports:
- clk  in  1  system clock, rising edge active
- rst  in  1  synchronous, active-high reset
- bus  in  Bits  common bus value from the bus multiplexer
- alu_out  in  Bits  ALU result, source for AC load
- ar_ld, ar_inr, ar_clr  in  1 each  AR controls
- pc_ld, pc_inr, pc_clr  in  1 each  PC controls
- dr_ld, dr_inr, dr_clr  in  1 each  DR controls
- ac_ld, ac_inr, ac_clr  in  1 each  AC controls
- ir_ld  in  1  IR load (IR has no inr/clr)
- tr_ld, tr_inr, tr_clr  in  1 each  TR controls
- sc_inr, sc_clr  in  1 each  sequence counter controls
- mem_write  in  1  memory write request from control
- ar, pc  out  12  register values
- dr, ac, ir, tr  out  Bits  register values
- sc  out  4  sequence counter value
- t  out  16  one-hot decode of sc (t[sc] = 1)
- mem_we  out  1  memory write enable
- mem_addr  out  12  memory address
- mem_wdata  out  Bits  memory write data

## Operation

- All register updates occur on the rising edge of clk. No update happens when no control is asserted.
- Per-register priority when strobes coincide: rst > clr > ld > inr. Lower-priority strobes are ignored that cycle.
- AR and PC load bus[11:0]. The upper bus bits are ignored.
- DR, IR and TR load bus[Bits-1:0]. AC loads alu_out, never bus.
- Increment is modulo register width:
  - AR/PC wrap 12'hFFF -> 12'h000.
  - DR/AC/TR wrap all-ones -> 0.
  - SC wraps 4'hF -> 4'h0.
- SC: sc_clr has priority over sc_inr. t is a combinational decode of the registered sc, so exactly one bit of t is always high.
- Memory port is combinational:
  - mem_we = mem_write.
  - mem_addr = ar (current registered value).
  - mem_wdata = bus.
  - mem_we is forced to 0 while rst = 1.
- Load-from-self is legal. Example: pc_ld with bus = pc holds the value.
- Strobes to different registers in the same cycle are independent and all take effect.

## Timing

- Reset, sampled at the clock edge: ar, pc, dr, ac, ir, tr, sc all become 0. t = 16'h0001. mem_we = 0.
- Reset asserted mid-sequence overrides every strobe that cycle. Values are 0 after that edge, regardless of ld/inr.
- ld/inr/clr latency is one cycle: the new value is visible on the output after the edge at which the strobe was sampled high.
- Read-before-write: a register updated at edge N drives its old value to the bus multiplexer until edge N. This makes transfers such as AR<-PC with PC<-PC+1 in the same cycle correct. AR receives the pre-increment PC.
- Memory write address and data are sampled by memory at the same edge mem_we is high. AR updated at that edge does not affect that write.
- t changes one cycle after sc_inr/sc_clr.

## Test plan

- Reset: drive arbitrary strobes with rst = 1 for one edge. Required: all registers and sc = 0, t = 16'h0001, mem_we = 0.
- Priority: set AR = 12'h123, then assert ar_clr, ar_ld and ar_inr together with bus = 16'hFFFF. Required: ar = 0. Then ar_ld + ar_inr with bus = 16'hABCD. Required: ar = 12'hBCD.
- Wrap: PC = 12'hFFF with pc_inr gives pc = 0. AC = 16'hFFFF with ac_inr gives ac = 0. SC at 15 with sc_inr gives sc = 0 and t = 16'h0001.
- Simultaneous transfer: pc = 12'h010, bus = 16'h0010, assert ar_ld and pc_inr. Required after the edge: ar = 12'h010, pc = 12'h011.
- AC source: ac_ld with alu_out = 16'h5A5A and bus = 16'h1111. Required: ac = 16'h5A5A. ir_ld with bus = 16'h7800 gives ir = 16'h7800.
- Memory port: ar = 12'h0FE, bus = 16'hBEEF, mem_write = 1. Required same cycle: mem_we = 1, mem_addr = 12'h0FE, mem_wdata = 16'hBEEF. With rst = 1, mem_we = 0.

Source files
------------

// File: rtl/bus_reg_file.sv
// Register bank fed by the common bus: AR, PC, DR, AC, IR, TR and the sequence counter SC,
// each with clear > load > increment control, plus the memory write port driven from AR and the bus.
module bus_reg_file #(
    parameter int Bits = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [Bits-1:0] bus,
    input  logic [Bits-1:0] alu_out,
    input  logic            ar_ld,
    input  logic            ar_inr,
    input  logic            ar_clr,
    input  logic            pc_ld,
    input  logic            pc_inr,
    input  logic            pc_clr,
    input  logic            dr_ld,
    input  logic            dr_inr,
    input  logic            dr_clr,
    input  logic            ac_ld,
    input  logic            ac_inr,
    input  logic            ac_clr,
    input  logic            ir_ld,
    input  logic            tr_ld,
    input  logic            tr_inr,
    input  logic            tr_clr,
    input  logic            sc_inr,
    input  logic            sc_clr,
    input  logic            mem_write,
    output logic [11:0]     ar,
    output logic [11:0]     pc,
    output logic [Bits-1:0] dr,
    output logic [Bits-1:0] ac,
    output logic [Bits-1:0] ir,
    output logic [Bits-1:0] tr,
    output logic [3:0]      sc,
    output logic [15:0]     t,
    output logic            mem_we,
    output logic [11:0]     mem_addr,
    output logic [Bits-1:0] mem_wdata
);

    localparam logic [Bits-1:0] ONE_W = {{(Bits-1){1'b0}}, 1'b1};

    logic [11:0]     ar_q, ar_d;
    logic [11:0]     pc_q, pc_d;
    logic [Bits-1:0] dr_q, dr_d;
    logic [Bits-1:0] ac_q, ac_d;
    logic [Bits-1:0] ir_q, ir_d;
    logic [Bits-1:0] tr_q, tr_d;
    logic [3:0]      sc_q, sc_d;

    // Next-state selection for the 12-bit address registers
    always_comb begin
        ar_d = ar_q;
        if (ar_clr)      ar_d = 12'h000;
        else if (ar_ld)  ar_d = bus[11:0];
        else if (ar_inr) ar_d = ar_q + 12'h001;
        else             ar_d = ar_q;

        pc_d = pc_q;
        if (pc_clr)      pc_d = 12'h000;
        else if (pc_ld)  pc_d = bus[11:0];
        else if (pc_inr) pc_d = pc_q + 12'h001;
        else             pc_d = pc_q;
    end

    // Next-state selection for the full-width data registers; AC loads from the ALU, never the bus
    always_comb begin
        dr_d = dr_q;
        if (dr_clr)      dr_d = '0;
        else if (dr_ld)  dr_d = bus;
        else if (dr_inr) dr_d = dr_q + ONE_W;
        else             dr_d = dr_q;

        ac_d = ac_q;
        if (ac_clr)      ac_d = '0;
        else if (ac_ld)  ac_d = alu_out;
        else if (ac_inr) ac_d = ac_q + ONE_W;
        else             ac_d = ac_q;

        ir_d = ir_q;
        if (ir_ld) ir_d = bus;
        else       ir_d = ir_q;

        tr_d = tr_q;
        if (tr_clr)      tr_d = '0;
        else if (tr_ld)  tr_d = bus;
        else if (tr_inr) tr_d = tr_q + ONE_W;
        else             tr_d = tr_q;
    end

    // Sequence counter next state
    always_comb begin
        sc_d = sc_q;
        if (sc_clr)      sc_d = 4'h0;
        else if (sc_inr) sc_d = sc_q + 4'h1;
        else             sc_d = sc_q;
    end

    // State registers with synchronous reset overriding every strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_q <= 12'h000;
            pc_q <= 12'h000;
            dr_q <= '0;
            ac_q <= '0;
            ir_q <= '0;
            tr_q <= '0;
            sc_q <= 4'h0;
        end else begin
            ar_q <= ar_d;
            pc_q <= pc_d;
            dr_q <= dr_d;
            ac_q <= ac_d;
            ir_q <= ir_d;
            tr_q <= tr_d;
            sc_q <= sc_d;
        end
    end

    // One-hot timing decode of the registered counter
    always_comb begin
        t       = 16'h0000;
        t[sc_q] = 1'b1;
    end

    assign ar = ar_q;
    assign pc = pc_q;
    assign dr = dr_q;
    assign ac = ac_q;
    assign ir = ir_q;
    assign tr = tr_q;
    assign sc = sc_q;

    // Memory samples address and data at the same edge, so pre-update AR is what it sees
    assign mem_we    = mem_write & ~rst;
    assign mem_addr  = ar_q;
    assign mem_wdata = bus;

endmodule

// File: tb/tb_bus_reg_file.sv
// Randomized and directed bench for bus_reg_file against a behavioural register-transfer model.
module tb_bus_reg_file;

    localparam int Bits = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [Bits-1:0] bus, alu_out;
    logic ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr;
    logic dr_ld, dr_inr, dr_clr, ac_ld, ac_inr, ac_clr, ir_ld;
    logic tr_ld, tr_inr, tr_clr, sc_inr, sc_clr, mem_write;
    logic [11:0]     ar, pc, mem_addr;
    logic [Bits-1:0] dr, ac, ir, tr, mem_wdata;
    logic [3:0]      sc;
    logic [15:0]     t;
    logic            mem_we;

    int tests = 0;
    int fails = 0;

    // behavioural model state
    int m_ar, m_pc, m_dr, m_ac, m_ir, m_tr, m_sc;

    always #5 clk = ~clk;

    bus_reg_file #(.Bits(Bits)) dut (
        .clk(clk), .rst(rst), .bus(bus), .alu_out(alu_out),
        .ar_ld(ar_ld), .ar_inr(ar_inr), .ar_clr(ar_clr),
        .pc_ld(pc_ld), .pc_inr(pc_inr), .pc_clr(pc_clr),
        .dr_ld(dr_ld), .dr_inr(dr_inr), .dr_clr(dr_clr),
        .ac_ld(ac_ld), .ac_inr(ac_inr), .ac_clr(ac_clr),
        .ir_ld(ir_ld),
        .tr_ld(tr_ld), .tr_inr(tr_inr), .tr_clr(tr_clr),
        .sc_inr(sc_inr), .sc_clr(sc_clr), .mem_write(mem_write),
        .ar(ar), .pc(pc), .dr(dr), .ac(ac), .ir(ir), .tr(tr),
        .sc(sc), .t(t), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // a register's next value: clear beats load beats increment, arithmetic modulo 2**w
    function automatic int rule(input int cur, input int w, input bit clr, input bit ld,
                                input int ldv, input bit inr);
        int modv = 1 << w;
        if (clr) return 0;
        if (ld)  return ldv % modv;
        if (inr) return (cur + 1) % modv;
        return cur;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_tr = 0; m_sc = 0;
        end else begin
            m_ar = rule(m_ar, 12, ar_clr, ar_ld, int'(bus), ar_inr);
            m_pc = rule(m_pc, 12, pc_clr, pc_ld, int'(bus), pc_inr);
            m_dr = rule(m_dr, Bits, dr_clr, dr_ld, int'(bus), dr_inr);
            m_ac = rule(m_ac, Bits, ac_clr, ac_ld, int'(alu_out), ac_inr);
            m_ir = rule(m_ir, Bits, 1'b0, ir_ld, int'(bus), 1'b0);
            m_tr = rule(m_tr, Bits, tr_clr, tr_ld, int'(bus), tr_inr);
            m_sc = rule(m_sc, 4, sc_clr, 1'b0, 0, sc_inr);
        end
    endtask

    task automatic compare_regs();
        check("ar", int'(ar), m_ar);
        check("pc", int'(pc), m_pc);
        check("dr", int'(dr), m_dr);
        check("ac", int'(ac), m_ac);
        check("ir", int'(ir), m_ir);
        check("tr", int'(tr), m_tr);
        check("sc", int'(sc), m_sc);
        check("t",  int'(t), 1 << m_sc);
    endtask

    task automatic compare_mem();
        check("mem_we",    int'(mem_we), (mem_write && !rst) ? 1 : 0);
        check("mem_addr",  int'(mem_addr), m_ar);
        check("mem_wdata", int'(mem_wdata), int'(bus));
    endtask

    task automatic idle();
        rst = 1'b0; bus = '0; alu_out = '0; mem_write = 1'b0;
        {ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr} = 6'b000000;
        {dr_ld, dr_inr, dr_clr, ac_ld, ac_inr, ac_clr, ir_ld} = 7'b0000000;
        {tr_ld, tr_inr, tr_clr, sc_inr, sc_clr} = 5'b00000;
    endtask

    // one clock: model advances with the inputs sampled at the edge, then every output is compared
    task automatic step();
        #1 compare_mem();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_regs();
    endtask

    initial begin
        idle();
        @(negedge clk);

        // reset with every strobe asserted
        {ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr} = 6'b111111;
        {dr_ld, dr_inr, dr_clr, ac_ld, ac_inr, ac_clr, ir_ld} = 7'b1111111;
        {tr_ld, tr_inr, tr_clr, sc_inr, sc_clr} = 5'b11111;
        bus = 16'h1234; alu_out = 16'h4321; mem_write = 1'b1; rst = 1'b1;
        #1 check("rst_mem_we_lit", int'(mem_we), 0);
        step();
        check("rst_ar_lit", int'(ar), 0);
        check("rst_ac_lit", int'(ac), 0);
        check("rst_t_lit", int'(t), 16'h0001);

        // priority
        idle(); ar_ld = 1'b1; bus = 16'h0123; step();
        idle(); ar_clr = 1'b1; ar_ld = 1'b1; ar_inr = 1'b1; bus = 16'hFFFF; step();
        check("prio_clr_lit", int'(ar), 0);
        idle(); ar_ld = 1'b1; ar_inr = 1'b1; bus = 16'hABCD; step();
        check("prio_ld_lit", int'(ar), 12'hBCD);

        // wrap-around
        idle(); pc_ld = 1'b1; bus = 16'hFFFF; ac_ld = 1'b1; alu_out = 16'hFFFF; step();
        idle(); pc_inr = 1'b1; ac_inr = 1'b1; step();
        check("pc_wrap_lit", int'(pc), 0);
        check("ac_wrap_lit", int'(ac), 0);
        idle(); sc_clr = 1'b1; sc_inr = 1'b1; step();
        check("sc_clr_prio_lit", int'(sc), 0);
        for (int i = 0; i < 15; i++) begin
            idle(); sc_inr = 1'b1; step();
        end
        check("sc15_t_lit", int'(t), 16'h8000);
        idle(); sc_inr = 1'b1; step();
        check("sc_wrap_lit", int'(sc), 0);
        check("sc_wrap_t_lit", int'(t), 16'h0001);

        // AR <- PC while PC increments
        idle(); pc_ld = 1'b1; bus = 16'h0010; step();
        idle(); ar_ld = 1'b1; pc_inr = 1'b1; bus = 16'h0010; step();
        check("xfer_ar_lit", int'(ar), 12'h010);
        check("xfer_pc_lit", int'(pc), 12'h011);

        // AC source and IR load in the same cycle
        idle(); ac_ld = 1'b1; alu_out = 16'h5A5A; ir_ld = 1'b1; bus = 16'h7800; step();
        check("ac_src_lit", int'(ac), 16'h5A5A);
        check("ir_ld_lit", int'(ir), 16'h7800);

        // memory port, with AR changing at the write edge
        idle(); ar_ld = 1'b1; bus = 16'h00FE; step();
        idle(); bus = 16'hBEEF; mem_write = 1'b1; ar_inr = 1'b1;
        #1;
        check("mem_we_lit", int'(mem_we), 1);
        check("mem_addr_lit", int'(mem_addr), 12'h0FE);
        check("mem_wdata_lit", int'(mem_wdata), 16'hBEEF);
        step();
        rst = 1'b1;
        #1 check("mem_we_rst_lit", int'(mem_we), 0);
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            bus       = 16'($urandom);
            alu_out   = 16'($urandom);
            mem_write = 1'($urandom);
            {ar_ld, ar_inr, ar_clr} = {($urandom_range(0,3)==0), ($urandom_range(0,2)==0), ($urandom_range(0,9)==0)};
            {pc_ld, pc_inr, pc_clr} = {($urandom_range(0,3)==0), ($urandom_range(0,2)==0), ($urandom_range(0,9)==0)};
            {dr_ld, dr_inr, dr_clr} = {($urandom_range(0,3)==0), ($urandom_range(0,2)==0), ($urandom_range(0,9)==0)};
            {ac_ld, ac_inr, ac_clr} = {($urandom_range(0,3)==0), ($urandom_range(0,2)==0), ($urandom_range(0,9)==0)};
            {tr_ld, tr_inr, tr_clr} = {($urandom_range(0,3)==0), ($urandom_range(0,2)==0), ($urandom_range(0,9)==0)};
            ir_ld  = ($urandom_range(0,3) == 0);
            sc_inr = ($urandom_range(0,1) == 0);
            sc_clr = ($urandom_range(0,11) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
